muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide engine that replaces the separate fixed-width mult and div blocks feeding the HI/LO registers.
- Parametrised in operand width; supports signed and unsigned multiply and divide.
- Uses a start/busy/done handshake so the control unit can stall on it.
- Flags divide-by-zero for the exception path (Cause/EPC).

Parameters:
- WIDTH, 32, operand width in bits; hi/lo are each WIDTH bits; must be >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu
- a  input  WIDTH  multiplicand / dividend
- b  input  WIDTH  multiplier / divisor
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; hi/lo (or div_zero) are valid from this cycle
- div_zero  output  1  one-cycle pulse coincident with done when a divide has b==0
- hi  output  WIDTH  mult: upper product half; div: remainder
- lo  output  WIDTH  mult: lower product half; div: quotient

Behaviour:
- Reset:
  - Synchronous, active-high; state goes to IDLE.
  - busy, done, div_zero, hi, lo and all internal registers go to 0.
  - Reset mid-operation aborts it: no done pulse, hi/lo become 0.
- States: IDLE, CALC, FIX, DZ.
- IDLE:
  - On an edge with start=1, latch op, |a| and |b| (magnitudes for signed ops), and the result signs; counter = WIDTH.
  - If op is a divide and b==0, go to DZ; otherwise go to CALC.
  - start=0: remain in IDLE.
- CALC, one iteration per edge, counter decrements, go to FIX when the counter reaches 0 (WIDTH edges):
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
- FIX (one edge):
  - Apply sign correction (two's complement negate) and write hi/lo.
  - done=1 for the following cycle; return to IDLE.
- DZ (one edge):
  - done=1 and div_zero=1 for the following cycle; return to IDLE.
  - hi/lo unchanged.
- Timing:
  - start accepted on edge E0; busy=1 from after E0 through the cycle before done.
  - Normal op: done high in the cycle after edge E(WIDTH+1), i.e. a latency of WIDTH+2 edges.
  - Divide-by-zero: done high after E1.
- busy and done are never high together.
- start while busy (CALC/FIX/DZ) is ignored, not queued.
- A start asserted in the same cycle as done is accepted, since the state is IDLE.
- hi/lo hold their value until the next completing FIX; they change only at FIX.
- a/b/op may change after E0 without effect.
- Signed multiply: full 2*WIDTH two's-complement product.
- Signed divide:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN/-1 gives lo=MIN (wraps) and hi=0, with no flag.
- Unsigned ops: operands are treated as pure magnitudes with no sign fix.

Test Plan:
- WIDTH=32, mult a=0xFFFFFFFD (-3), b=7, start pulse at E0 -> done in cycle after E33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
- multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then mult on the same operands -> hi=0, lo=1.
- div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 -> lo=14, hi=2. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- div or divu with b=0, hi/lo previously 0x12/0x34 -> done and div_zero high in the cycle after E1, hi/lo still 0x12/0x34, busy high for 1 cycle.
- Second start pulse at E5 during a mult -> ignored, one done only. Start asserted during the done cycle -> new op runs, done again 34 cycles later.
- Reset asserted at E10 of a divide -> busy=0, hi=lo=0, no done. The next divu 9/3 completes normally with lo=3, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine feeding the HI/LO registers.
// Radix-2 shift-add multiply and restoring shift-subtract divide share one
// 2*WIDTH accumulator: the upper half is the partial product / remainder and
// the lower half is the multiplier being consumed / quotient being built.
// Signed operations run on magnitudes and the sign is fixed up in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DZ
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH-1:0] acc;

  logic               is_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  // Operand magnitudes for the request currently on the inputs (op[0]=0 means signed).
  always_comb begin
    is_signed = ~op[0];
    a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
  end

  // One multiply or divide step; diff[WIDTH] set means the trial subtract underflowed.
  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    shifted = acc[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, operand};
    if (!is_div) begin
      acc_next = {add_sum, acc[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction: the product negates as one 2*WIDTH value, quotient and remainder separately.
  always_comb begin
    prod_fixed = neg_lo ? -acc : acc;
    quot_fixed = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fixed  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM with registered handshake outputs and HI/LO write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      operand  <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div  <= op[1];
            operand <= b_mag;
            acc     <= {{WIDTH{1'b0}}, a_mag};
            count   <= CNT_W'(WIDTH);
            neg_lo  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi  <= is_signed & a[WIDTH-1];
            busy    <= 1'b1;
            state   <= (op[1] && (b == '0)) ? DZ : CALC;
          end
        end
        CALC: begin
          acc   <= acc_next;
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fixed;
            lo <= quot_fixed;
          end else begin
            hi <= prod_fixed[2*WIDTH-1:WIDTH];
            lo <= prod_fixed[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        DZ: begin
          done     <= 1'b1;
          div_zero <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at WIDTH=32.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_muldiv_unit;

  localparam int W = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks_total;
  int checks_passed;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks_total++;
    if (observed === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one request for a single cycle; returns at the falling edge after it was accepted.
  task automatic applyStimulus(input logic [1:0] op_in, input logic [W-1:0] a_in, input logic [W-1:0] b_in);
    op    = op_in;
    a     = a_in;
    b     = b_in;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 32'hDEAD_BEEF;
    b     = 32'h0BAD_F00D;
    op    = ~op_in;
  endtask

  // Wait for done with a cycle bound; edges counts clock edges since acceptance.
  // poke >= 0 raises start for one cycle so that it is sampled on edge poke+1.
  task automatic waitDone(input int poke, output int edges, output int busy_cycles);
    int n;
    n = 0;
    busy_cycles = 0;
    while (!done && n < 100) begin
      if (busy) busy_cycles++;
      start = (n == poke);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    edges = n;
    checkOutput("done_seen", 64'(done), 64'd1);
    checkOutput("busy_off_at_done", 64'(busy), 64'd0);
  endtask

  // Full transaction: launch, wait, check latency/results, confirm done is a single pulse.
  task automatic runOp(input string tag, input logic [1:0] op_in, input logic [W-1:0] a_in,
                       input logic [W-1:0] b_in, input logic [W-1:0] exp_hi,
                       input logic [W-1:0] exp_lo, input logic exp_dz);
    int edges;
    int busy_cycles;
    int exp_edges;
    exp_edges = exp_dz ? 1 : W + 1;
    applyStimulus(op_in, a_in, b_in);
    waitDone(-1, edges, busy_cycles);
    checkOutput({tag, "_latency"}, 64'(edges), 64'(exp_edges));
    checkOutput({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(exp_edges));
    checkOutput({tag, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
    checkOutput({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    checkOutput({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
    checkOutput({tag, "_dz_pulse"}, 64'(div_zero), 64'd0);
  endtask

  // Count done pulses over a window where none should appear.
  task automatic expectQuiet(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    checkOutput({tag, "_no_done"}, 64'(pulses), 64'd0);
    checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int edges;
    int busy_cycles;
    checks_total  = 0;
    checks_passed = 0;
    reset = 1'b1;
    start = 1'b0;
    op    = OP_MULT;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);

    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_div_zero", 64'(div_zero), 64'd0);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] multiply vectors");
    runOp("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    runOp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    runOp("mult_m1xm1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
    runOp("mult_pos", OP_MULT, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 32'h0000_0000, 1'b0);

    $display("[TB] divide vectors");
    runOp("div_m7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    runOp("divu_100by7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    runOp("div_min_by_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    runOp("div_7by_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);

    $display("[TB] divide by zero");
    runOp("divu_preset", OP_DIVU, 32'h0000_0692, 32'h0000_0020, 32'h12, 32'h34, 1'b0);
    runOp("div_by0", OP_DIV, 32'd5, 32'd0, 32'h12, 32'h34, 1'b1);
    runOp("divu_by0", OP_DIVU, 32'hFFFF_FFFF, 32'd0, 32'h12, 32'h34, 1'b1);

    $display("[TB] start while busy is ignored");
    applyStimulus(OP_MULT, 32'd6, 32'd7);
    waitDone(4, edges, busy_cycles);
    checkOutput("poke_latency", 64'(edges), 64'(W + 1));
    checkOutput("poke_lo", 64'(lo), 64'd42);
    @(negedge clk);
    expectQuiet("poke", 40);

    $display("[TB] start during the done cycle");
    applyStimulus(OP_MULTU, 32'd5, 32'd9);
    waitDone(-1, edges, busy_cycles);
    checkOutput("b2b_first_lo", 64'(lo), 64'd45);
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    checkOutput("b2b_done_cleared", 64'(done), 64'd0);
    checkOutput("b2b_busy", 64'(busy), 64'd1);
    waitDone(-1, edges, busy_cycles);
    checkOutput("b2b_latency", 64'(edges), 64'(W + 1));
    checkOutput("b2b_hi", 64'(hi), 64'd2);
    checkOutput("b2b_lo", 64'(lo), 64'd14);
    @(negedge clk);

    $display("[TB] reset mid-divide");
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    checkOutput("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_hi", 64'(hi), 64'd0);
    checkOutput("abort_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    expectQuiet("abort", 40);
    runOp("divu_9by3", OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
